// File: rtl/segre_pkg.sv
// Shared types for the writeback path: result-entry layout, source ids, widths.
package segre_pkg;

    localparam int WORD_SIZE  = 32;
    localparam int REG_SIZE   = 5;
    localparam int HF_PTR     = 4;
    localparam int WB_NUM_SRC = 3;

    typedef struct packed {
        logic [REG_SIZE-1:0]  waddr;
        logic [WORD_SIZE-1:0] data;
        logic [HF_PTR-1:0]    instr_id;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_RVM = 2'd2
    } wb_src_e;

endpackage

// File: rtl/segre_wb_fifo.sv
// Per-source result FIFO. A push is taken when not full, or when full but
// popped in the same cycle. Count is one bit wider than the pointers.
module segre_wb_fifo
    import segre_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rsn_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  wb_entry_t                  entry_i,
    output wb_entry_t                  head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    wb_entry_t        mem_q [DEPTH];

    logic wr_en, rd_en, full;

    assign full   = (count_q == (PTR_W+1)'(DEPTH));
    assign rd_en  = pop_i && (count_q != '0);
    assign wr_en  = push_i && (!full || rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= entry_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/segre_wb_arbiter.sv
// Writeback arbiter: ALU/MEM/RVM result FIFOs merged onto one RF write port.
// SEGRE_WB_ROUND_ROBIN_EN selects round-robin; default is fixed MEM>RVM>ALU.
module segre_wb_arbiter
    import segre_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STALL_MARGIN = 2
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,

    input  logic                 alu_rf_we_i,
    input  logic [REG_SIZE-1:0]  alu_rf_waddr_i,
    input  logic [WORD_SIZE-1:0] alu_data_i,
    input  logic [HF_PTR-1:0]    alu_instr_id_i,
    output logic                 alu_stall_o,

    input  logic                 mem_rf_we_i,
    input  logic [REG_SIZE-1:0]  mem_rf_waddr_i,
    input  logic [WORD_SIZE-1:0] mem_data_i,
    input  logic [HF_PTR-1:0]    mem_instr_id_i,
    output logic                 mem_stall_o,

    input  logic                 rvm_rf_we_i,
    input  logic [REG_SIZE-1:0]  rvm_rf_waddr_i,
    input  logic [WORD_SIZE-1:0] rvm_data_i,
    input  logic [HF_PTR-1:0]    rvm_instr_id_i,
    output logic                 rvm_stall_o,

    output logic                 rf_we_o,
    output logic [REG_SIZE-1:0]  rf_waddr_o,
    output logic [WORD_SIZE-1:0] rf_data_o,
    output logic [HF_PTR-1:0]    instr_id_o,
    output logic                 overflow_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [WB_NUM_SRC-1:0] we, push, pop, full, nonempty, stall;
    wb_entry_t             in_entry [WB_NUM_SRC];
    wb_entry_t             head     [WB_NUM_SRC];
    logic [CNT_W-1:0]      count    [WB_NUM_SRC];

    logic      gnt_valid;
    wb_src_e   gnt_src;

    logic      rf_we_q, rf_we_d;
    wb_entry_t out_q, out_d;
    logic      ovf_q, ovf_d;

    assign we[WB_ALU] = alu_rf_we_i;
    assign we[WB_MEM] = mem_rf_we_i;
    assign we[WB_RVM] = rvm_rf_we_i;

    assign in_entry[WB_ALU] = '{waddr: alu_rf_waddr_i, data: alu_data_i, instr_id: alu_instr_id_i};
    assign in_entry[WB_MEM] = '{waddr: mem_rf_waddr_i, data: mem_data_i, instr_id: mem_instr_id_i};
    assign in_entry[WB_RVM] = '{waddr: rvm_rf_waddr_i, data: rvm_data_i, instr_id: rvm_instr_id_i};

    for (genvar s = 0; s < WB_NUM_SRC; s++) begin : g_src
        // x0 writes are architecturally void; keep them out of the FIFO.
        assign push[s]     = we[s] && (in_entry[s].waddr != '0);
        assign full[s]     = (count[s] == CNT_W'(FIFO_DEPTH));
        assign nonempty[s] = (count[s] != '0);
        assign stall[s]    = (count[s] >= CNT_W'(FIFO_DEPTH - STALL_MARGIN));

        segre_wb_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rsn_i   (rsn_i),
            .push_i  (push[s]),
            .pop_i   (pop[s]),
            .entry_i (in_entry[s]),
            .head_o  (head[s]),
            .count_o (count[s])
        );
    end

`ifdef SEGRE_WB_ROUND_ROBIN_EN
    wb_src_e last_q;

    always_comb begin
        int idx;
        gnt_valid = 1'b0;
        gnt_src   = WB_ALU;
        idx       = 0;
        // Scan cyclically starting just after the last winner.
        for (int k = 1; k <= WB_NUM_SRC; k++) begin
            idx = (int'(last_q) + k) % WB_NUM_SRC;
            if (!gnt_valid && nonempty[idx]) begin
                gnt_valid = 1'b1;
                gnt_src   = wb_src_e'(idx);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i)          last_q <= WB_RVM;
        else if (gnt_valid) last_q <= gnt_src;
    end
`else
    always_comb begin
        gnt_valid = 1'b1;
        gnt_src   = WB_ALU;
        if (nonempty[WB_MEM])      gnt_src = WB_MEM;
        else if (nonempty[WB_RVM]) gnt_src = WB_RVM;
        else if (nonempty[WB_ALU]) gnt_src = WB_ALU;
        else                       gnt_valid = 1'b0;
    end
`endif

    always_comb begin
        pop = '0;
        for (int s = 0; s < WB_NUM_SRC; s++) begin
            pop[s] = gnt_valid && (gnt_src == wb_src_e'(s));
        end
    end

    always_comb begin
        rf_we_d = gnt_valid;
        out_d   = out_q;
        if (gnt_valid) out_d = head[gnt_src];
        // Overflow is a full FIFO that is not draining this cycle.
        ovf_d   = ovf_q | (|(push & full & ~pop));
    end

    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            rf_we_q <= 1'b0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            rf_we_q <= rf_we_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign rf_we_o     = rf_we_q;
    assign rf_waddr_o  = out_q.waddr;
    assign rf_data_o   = out_q.data;
    assign instr_id_o  = out_q.instr_id;
    assign overflow_o  = ovf_q;

    assign alu_stall_o = stall[WB_ALU];
    assign mem_stall_o = stall[WB_MEM];
    assign rvm_stall_o = stall[WB_RVM];

endmodule

// File: tb/tb_segre_wb_arbiter.sv
// Bench for segre_wb_arbiter: directed cases plus random traffic against a
// queue-based model of the writeback rules.
module tb_segre_wb_arbiter;
    import segre_pkg::*;

    localparam int DEPTH  = 4;
    localparam int MARGIN = 2;

    logic clk_i = 1'b0;
    logic rsn_i = 1'b0;

    logic                 we  [3];
    logic [REG_SIZE-1:0]  wa  [3];
    logic [WORD_SIZE-1:0] wd  [3];
    logic [HF_PTR-1:0]    wid [3];

    logic                 alu_stall_o, mem_stall_o, rvm_stall_o;
    logic                 rf_we_o, overflow_o;
    logic [REG_SIZE-1:0]  rf_waddr_o;
    logic [WORD_SIZE-1:0] rf_data_o;
    logic [HF_PTR-1:0]    instr_id_o;

    segre_wb_arbiter #(
        .FIFO_DEPTH   (DEPTH),
        .STALL_MARGIN (MARGIN)
    ) dut (
        .clk_i          (clk_i),
        .rsn_i          (rsn_i),
        .alu_rf_we_i    (we[0]),
        .alu_rf_waddr_i (wa[0]),
        .alu_data_i     (wd[0]),
        .alu_instr_id_i (wid[0]),
        .alu_stall_o    (alu_stall_o),
        .mem_rf_we_i    (we[1]),
        .mem_rf_waddr_i (wa[1]),
        .mem_data_i     (wd[1]),
        .mem_instr_id_i (wid[1]),
        .mem_stall_o    (mem_stall_o),
        .rvm_rf_we_i    (we[2]),
        .rvm_rf_waddr_i (wa[2]),
        .rvm_data_i     (wd[2]),
        .rvm_instr_id_i (wid[2]),
        .rvm_stall_o    (rvm_stall_o),
        .rf_we_o        (rf_we_o),
        .rf_waddr_o     (rf_waddr_o),
        .rf_data_o      (rf_data_o),
        .instr_id_o     (instr_id_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    wb_entry_t q [3][$];
    int        last;
    bit        m_we;
    wb_entry_t m_out;
    bit        m_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 3; s++) q[s].delete();
        last  = 2;
        m_we  = 1'b0;
        m_out = '0;
        m_ovf = 1'b0;
    endtask

    task automatic model_step();
        int sel;
        int order [3];
        sel = -1;
`ifdef SEGRE_WB_ROUND_ROBIN_EN
        for (int k = 0; k < 3; k++) order[k] = (last + 1 + k) % 3;
`else
        order[0] = 1; order[1] = 2; order[2] = 0;
`endif
        for (int k = 0; k < 3; k++)
            if (sel < 0 && q[order[k]].size() > 0) sel = order[k];
        if (sel >= 0) begin
            m_out = q[sel].pop_front();
            m_we  = 1'b1;
            last  = sel;
        end else begin
            m_we  = 1'b0;
        end
        for (int s = 0; s < 3; s++) begin
            if (we[s] && wa[s] != '0) begin
                if (q[s].size() < DEPTH) q[s].push_back('{waddr: wa[s], data: wd[s], instr_id: wid[s]});
                else                     m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk("rf_we",    64'(rf_we_o),    64'(m_we));
        chk("rf_waddr", 64'(rf_waddr_o), 64'(m_out.waddr));
        chk("rf_data",  64'(rf_data_o),  64'(m_out.data));
        chk("instr_id", 64'(instr_id_o), 64'(m_out.instr_id));
        chk("overflow", 64'(overflow_o), 64'(m_ovf));
        chk("alu_stall", 64'(alu_stall_o), 64'(q[0].size() >= DEPTH - MARGIN));
        chk("mem_stall", 64'(mem_stall_o), 64'(q[1].size() >= DEPTH - MARGIN));
        chk("rvm_stall", 64'(rvm_stall_o), 64'(q[2].size() >= DEPTH - MARGIN));
    endtask

    task automatic clear_in();
        for (int s = 0; s < 3; s++) begin
            we[s] = 1'b0; wa[s] = '0; wd[s] = '0; wid[s] = '0;
        end
    endtask

    task automatic set_in(input int s, input logic [REG_SIZE-1:0] a,
                          input logic [WORD_SIZE-1:0] d, input logic [HF_PTR-1:0] id);
        we[s] = 1'b1; wa[s] = a; wd[s] = d; wid[s] = id;
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        clear_in();
        #1 rsn_i = 1'b1;
        #1;
        model_reset();
        chk("rst_we",  64'(rf_we_o),    64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);
        @(negedge clk_i);
        rsn_i = 1'b0;
    endtask

    logic [REG_SIZE-1:0] ord [3];

    initial begin
        clear_in();
        model_reset();
        #1 rsn_i = 1'b1;
        #2;
        chk("reset_we",    64'(rf_we_o),    64'd0);
        chk("reset_waddr", 64'(rf_waddr_o), 64'd0);
        chk("reset_data",  64'(rf_data_o),  64'd0);
        chk("reset_id",    64'(instr_id_o), 64'd0);
        chk("reset_ovf",   64'(overflow_o), 64'd0);
        chk("reset_stall", 64'({alu_stall_o, mem_stall_o, rvm_stall_o}), 64'd0);
        @(negedge clk_i);
        rsn_i = 1'b0;

        // Single MEM writeback
        set_in(1, 5'd5, 32'hDEADBEEF, 4'd3);
        tick();
        clear_in();
        tick();
        chk("single_we",   64'(rf_we_o),    64'd1);
        chk("single_addr", 64'(rf_waddr_o), 64'd5);
        chk("single_data", 64'(rf_data_o),  64'hDEADBEEF);
        chk("single_id",   64'(instr_id_o), 64'd3);
        tick();
        chk("single_idle", 64'(rf_we_o),    64'd0);

        // Simultaneous pushes from all three sources
`ifdef SEGRE_WB_ROUND_ROBIN_EN
        ord[0] = 5'd1; ord[1] = 5'd2; ord[2] = 5'd3;
`else
        ord[0] = 5'd2; ord[1] = 5'd3; ord[2] = 5'd1;
`endif
        do_reset();
        set_in(0, 5'd1, 32'h11, 4'd1);
        set_in(1, 5'd2, 32'h22, 4'd2);
        set_in(2, 5'd3, 32'h33, 4'd3);
        tick();
        clear_in();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("order_we",   64'(rf_we_o),    64'd1);
            chk("order_addr", 64'(rf_waddr_o), 64'(ord[k]));
        end
        tick();

        // x0 push is discarded
        set_in(1, 5'd0, 32'hFFFFFFFF, 4'd7);
        tick();
        clear_in();
        tick();
        chk("x0_we",    64'(rf_we_o),     64'd0);
        chk("x0_stall", 64'(mem_stall_o), 64'd0);
        chk("x0_ovf",   64'(overflow_o),  64'd0);

        // Three MEM pushes alongside a continuous ALU stream
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (!(q[0].size() >= DEPTH - MARGIN)) set_in(0, 5'(c + 8), 32'(c), 4'(c));
            else we[0] = 1'b0;
            if (c < 3) set_in(1, 5'(c + 20), 32'(100 + c), 4'(c));
            else we[1] = 1'b0;
            tick();
        end
        clear_in();
        repeat (8) tick();
        chk("stall_noovf", 64'(overflow_o), 64'd0);

        // ALU and MEM flood ignoring stall
        do_reset();
        for (int c = 0; c < 8; c++) begin
            set_in(0, 5'(c + 1), 32'(c + 200), 4'(c));
            set_in(1, 5'(c + 10), 32'(c + 300), 4'(c));
            tick();
        end
        clear_in();
`ifndef SEGRE_WB_ROUND_ROBIN_EN
        chk("flood_ovf", 64'(overflow_o), 64'd1);
`endif
        repeat (12) tick();

        // Asynchronous reset with all sources busy
        do_reset();
        for (int c = 0; c < 3; c++) begin
            for (int s = 0; s < 3; s++) set_in(s, 5'(s * 4 + c + 1), 32'(s * 16 + c), 4'(c));
            tick();
        end
        clear_in();
        #2 rsn_i = 1'b1;
        #1;
        model_reset();
        chk("arst_we",    64'(rf_we_o),    64'd0);
        chk("arst_addr",  64'(rf_waddr_o), 64'd0);
        chk("arst_data",  64'(rf_data_o),  64'd0);
        chk("arst_id",    64'(instr_id_o), 64'd0);
        chk("arst_stall", 64'({alu_stall_o, mem_stall_o, rvm_stall_o}), 64'd0);
        @(negedge clk_i);
        rsn_i = 1'b0;
        repeat (4) begin
            tick();
            chk("arst_nowb", 64'(rf_we_o), 64'd0);
        end

        // Random traffic; producers honour the model's stall view
        do_reset();
        for (int c = 0; c < 500; c++) begin
            for (int s = 0; s < 3; s++) begin
                if ($urandom_range(0, 1) == 1 && q[s].size() < DEPTH - MARGIN)
                    set_in(s, 5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)));
                else
                    we[s] = 1'b0;
            end
            tick();
        end
        clear_in();
        repeat (10) tick();
        chk("rand_noovf", 64'(overflow_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
